// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Sequencing controller for one traffic-light approach. It drives the
//   downstream light down-counter (one-hot load strobes plus count-enable
//   ticks), watches the counter's terminal-count flag, and decodes the lamps.
//   It also handles pedestrian requests and a night-time flashing-yellow mode.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_enable            run; when low the sequencer freezes
//   i_night             night request, forces flashing yellow
//   i_ped_req           pedestrian request level, sampled every cycle
//   i_last              counter terminal-count flag (count == 0)
//   o_init              registered one-hot load strobe: [0] green, [1] yellow, [2] red
//   o_cnt_en            counter decrement enable (one cycle per tick)
//   o_green/yellow/red  lamp drives
//   o_ped_walk          walk lamp, lit for the whole red phase
//   o_dbg_state         current FSM state (0 yellow, 1 red, 2 green, 3 flash)
//   o_dbg_ped_pending   pedestrian request latched, waiting for red
module traffic_light_ctrl #(
  parameter int pINIT_WIDTH      = 3,
  parameter int pTICK_DIV        = 4,
  parameter int pTICK_WIDTH      = 2,
  parameter int pMIN_GREEN_TICKS = 4,
  parameter int pGT_WIDTH        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic                   i_night,
  input  logic                   i_ped_req,
  input  logic                   i_last,
  output logic [pINIT_WIDTH-1:0] o_init,
  output logic                   o_cnt_en,
  output logic                   o_green,
  output logic                   o_yellow,
  output logic                   o_red,
  output logic                   o_ped_walk,
  output logic [1:0]             o_dbg_state,
  output logic                   o_dbg_ped_pending
);

  typedef enum logic [1:0] {
    S_YELLOW = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_FLASH  = 2'd3
  } state_e;

  localparam logic [pINIT_WIDTH-1:0] INIT_GREEN  = pINIT_WIDTH'(1);
  localparam logic [pINIT_WIDTH-1:0] INIT_YELLOW = pINIT_WIDTH'(2);
  localparam logic [pINIT_WIDTH-1:0] INIT_RED    = pINIT_WIDTH'(4);
  localparam logic [pTICK_WIDTH-1:0] TICK_LAST   = pTICK_WIDTH'(pTICK_DIV - 1);
  localparam logic [pGT_WIDTH-1:0]   MIN_GT      = pGT_WIDTH'(pMIN_GREEN_TICKS);
  localparam logic [pGT_WIDTH-1:0]   GT_MAX      = '1;

  state_e                   state_q, state_d;
  logic [pINIT_WIDTH-1:0]   init_q, init_d;
  logic [pTICK_WIDTH-1:0]   presc_q, presc_d;
  logic [pGT_WIDTH-1:0]     gt_q, gt_d;
  logic                     ped_pending_q, ped_pending_d;
  logic                     phase_q, phase_d;

  logic                     in_init;
  logic                     cnt_tick;
  logic                     early_exit;
  logic [pTICK_WIDTH-1:0]   presc_inc;

  // A nonzero load strobe marks the first cycle of a state; i_last is stale then.
  assign in_init    = |init_q;
  assign cnt_tick   = i_enable && (state_q != S_FLASH) && !in_init && (presc_q == TICK_LAST);
  assign early_exit = (state_q == S_GREEN) && ped_pending_q && (gt_q >= MIN_GT);
  assign presc_inc  = (presc_q == TICK_LAST) ? '0 : presc_q + pTICK_WIDTH'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_YELLOW;
      init_q        <= '0;
      presc_q       <= '0;
      gt_q          <= '0;
      ped_pending_q <= 1'b0;
      phase_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      init_q        <= init_d;
      presc_q       <= presc_d;
      gt_q          <= gt_d;
      ped_pending_q <= ped_pending_d;
      phase_q       <= phase_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic changing;
    state_d       = state_q;
    init_d        = '0;
    presc_d       = presc_q;
    gt_d          = gt_q;
    ped_pending_d = ped_pending_q;
    phase_d       = phase_q;
    changing      = 1'b0;

    if (i_night) begin
      state_d = S_FLASH;
    end else if (state_q == S_FLASH) begin
      // Leaving night mode is a normal transition, so a freeze holds it off.
      if (i_enable) state_d = S_RED;
    end else if (!in_init && i_enable && (i_last || early_exit)) begin
      case (state_q)
        S_YELLOW: state_d = S_RED;
        S_RED:    state_d = S_GREEN;
        default:  state_d = S_YELLOW;
      endcase
    end

    changing = (state_d != state_q);

    if (changing) begin
      case (state_d)
        S_GREEN:  init_d = INIT_GREEN;
        S_YELLOW: init_d = INIT_YELLOW;
        S_RED:    init_d = INIT_RED;
        default:  init_d = '0;
      endcase
    end

    // Every new state starts its prescaler from zero; the init cycle keeps it there.
    if (changing) begin
      presc_d = '0;
    end else if (i_enable && ((state_q == S_FLASH) || !in_init)) begin
      presc_d = presc_inc;
    end

    if (changing && (state_d == S_GREEN)) begin
      gt_d = '0;
    end else if ((state_q == S_GREEN) && cnt_tick && (gt_q != GT_MAX)) begin
      gt_d = gt_q + pGT_WIDTH'(1);
    end

    // Clearing on red entry takes priority over a request in the same cycle.
    if (changing && (state_d == S_RED)) begin
      ped_pending_d = 1'b0;
    end else if (i_ped_req && (state_q != S_RED) && (state_q != S_FLASH)) begin
      ped_pending_d = 1'b1;
    end

    if (changing && (state_d == S_FLASH)) begin
      phase_d = 1'b1;
    end else if ((state_q == S_FLASH) && i_enable && (presc_q == TICK_LAST)) begin
      phase_d = ~phase_q;
    end
  end

  // Output decode: lamps come from registers only
  always_comb begin
    o_green    = 1'b0;
    o_yellow   = 1'b0;
    o_red      = 1'b0;
    o_ped_walk = 1'b0;
    o_cnt_en   = cnt_tick;
    case (state_q)
      S_YELLOW: o_yellow = 1'b1;
      S_RED: begin
        o_red      = 1'b1;
        o_ped_walk = 1'b1;
      end
      S_GREEN:  o_green  = 1'b1;
      default:  o_yellow = phase_q;
    endcase
  end

  assign o_init            = init_q;
  assign o_dbg_state       = state_q;
  assign o_dbg_ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a behavioural light counter (green 14,
// yellow 2, red 17), a directed table of phase-boundary vectors, a
// mid-green reset sequence and randomized stimulus, all checked every
// cycle against a phase/age reference model.
module tb_traffic_light_ctrl;

  localparam int DIV   = 4;
  localparam int MIN_G = 4;
  localparam int M_Y = 0, M_R = 1, M_G = 2, M_F = 3;
  localparam logic [3:0] L_Y = 4'b0100, L_R = 4'b0011, L_G = 4'b1000, L_OFF = 4'b0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_enable = 1'b0, i_night = 1'b0, i_ped_req = 1'b0;
  logic i_last;
  logic [2:0] o_init;
  logic o_cnt_en, o_green, o_yellow, o_red, o_ped_walk;
  logic [1:0] dbg_state;
  logic dbg_pp;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_enable          (i_enable),
    .i_night           (i_night),
    .i_ped_req         (i_ped_req),
    .i_last            (i_last),
    .o_init            (o_init),
    .o_cnt_en          (o_cnt_en),
    .o_green           (o_green),
    .o_yellow          (o_yellow),
    .o_red             (o_red),
    .o_ped_walk        (o_ped_walk),
    .o_dbg_state       (dbg_state),
    .o_dbg_ped_pending (dbg_pp)
  );

  // downstream light counter
  logic [4:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= 5'd2;
    else if (o_init[0])             cnt_q <= 5'd14;
    else if (o_init[1])             cnt_q <= 5'd2;
    else if (o_init[2])             cnt_q <= 5'd17;
    else if (o_cnt_en && cnt_q != 0) cnt_q <= cnt_q - 5'd1;
  end
  assign i_last = (cnt_q == 5'd0);

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  logic [3:0] s_lamps;
  logic [2:0] s_init;
  logic s_pp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: phase, whether this is its first cycle, and the number
  // of enabled counting cycles spent in it so far
  int m_state;
  bit m_init;
  int m_age;
  bit m_pp;

  function automatic int load_of(input int s);
    case (s)
      M_G:     return 14;
      M_Y:     return 2;
      default: return 17;
    endcase
  endfunction

  function automatic int next_of(input int s);
    case (s)
      M_Y:     return M_R;
      M_R:     return M_G;
      default: return M_Y;
    endcase
  endfunction

  function automatic logic [3:0] m_lamps();
    case (m_state)
      M_Y:     return L_Y;
      M_R:     return L_R;
      M_G:     return L_G;
      default: return (((m_age / DIV) % 2) == 0) ? L_Y : L_OFF;
    endcase
  endfunction

  function automatic logic [2:0] m_initv();
    if (!m_init) return 3'b000;
    case (m_state)
      M_G:     return 3'b001;
      M_Y:     return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic bit m_cnt(input bit en);
    return en && (m_state != M_F) && !m_init && ((m_age % DIV) == DIV - 1);
  endfunction

  task automatic model_reset();
    m_state = M_Y;
    m_init  = 1'b0;
    m_age   = 0;
    m_pp    = 1'b0;
  endtask

  task automatic model_next(input bit en, input bit night, input bit ped);
    int ns, na;
    bit ni, npp;
    ns  = m_state;
    na  = m_age;
    ni  = 1'b0;
    npp = m_pp;
    if (night) begin
      ns = M_F;
      na = (m_state == M_F) ? m_age + int'(en) : 0;
    end else if (m_state == M_F) begin
      if (en) begin ns = M_R; ni = 1'b1; na = 0; end
    end else if (m_init) begin
      na = 0;
    end else if (en) begin
      if (m_age == load_of(m_state) * DIV ||
          (m_state == M_G && m_pp && (m_age / DIV) >= MIN_G)) begin
        ns = next_of(m_state); ni = 1'b1; na = 0;
      end else begin
        na = m_age + 1;
      end
    end
    if (ns == M_R && m_state != M_R) npp = 1'b0;
    else if (ped && m_state != M_R && m_state != M_F) npp = 1'b1;
    m_state = ns; m_init = ni; m_age = na; m_pp = npp;
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input bit en, input bit night, input bit ped);
    logic [8:0] act, exp;
    i_enable = en; i_night = night; i_ped_req = ped;
    #1;
    s_lamps = {o_green, o_yellow, o_red, o_ped_walk};
    s_init  = o_init;
    s_pp    = dbg_pp;
    act = {s_lamps, s_init, o_cnt_en, s_pp};
    exp = {m_lamps(), m_initv(), m_cnt(en), m_pp};
    check("model", int'(act), int'(exp));
    if (o_cnt_en) pulses++;
    model_next(en, night, ped);
    @(negedge clk);
  endtask

  typedef struct {
    bit en, night, ped;
    int len;
    logic [3:0] lamps;
    logic [2:0] init;
    bit pp;
    int pulses;   // cnt_en pulses expected during the row, -1 = not checked
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit en, input bit night, input bit ped, input int len,
                     input logic [3:0] lamps, input logic [2:0] init, input bit pp,
                     input int np);
    vec_t v;
    v.en = en; v.night = night; v.ped = ped; v.len = len;
    v.lamps = lamps; v.init = init; v.pp = pp; v.pulses = np;
    tbl.push_back(v);
  endtask

  int p0;
  int yl;
  bit night_r;
  bit en_r, ped_r;

  initial begin
    // normal sequence from reset release (cycle numbers in comments)
    add(1,0,0, 1, L_Y,  3'b000,0,-1);  // 0
    add(1,0,0, 8, L_Y,  3'b000,0,-1);  // 8  last yellow
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 9  red init
    add(1,0,0,69, L_R,  3'b000,0,17);  // 78 last red
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 79
    add(1,0,0,57, L_G,  3'b000,0,14);  // 136
    add(1,0,0, 1, L_Y,  3'b010,0,-1);  // 137
    add(1,0,0, 9, L_Y,  3'b000,0, 2);  // 146
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 147
    add(1,0,0,69, L_R,  3'b000,0,17);  // 216
    // pedestrian pulse at green tick 1 -> 18-cycle green
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 217
    add(1,0,0, 5, L_G,  3'b000,0,-1);  // 222
    add(1,0,1, 1, L_G,  3'b000,0,-1);  // 223
    add(1,0,0,11, L_G,  3'b000,1, 3);  // 234 last green
    add(1,0,0, 1, L_Y,  3'b010,1,-1);  // 235
    add(1,0,0, 9, L_Y,  3'b000,1,-1);  // 244
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 245 pending cleared
    // freeze 20 cycles mid-red -> 90-cycle red
    add(1,0,0,20, L_R,  3'b000,0, 5);  // 265
    add(0,0,0,20, L_R,  3'b000,0, 0);  // 285
    add(1,0,0,49, L_R,  3'b000,0,12);  // 334
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 335
    // night mid-green
    add(1,0,0,10, L_G,  3'b000,0,-1);  // 345
    add(1,1,0, 1, L_G,  3'b000,0,-1);  // 346
    add(1,1,0, 4, L_Y,  3'b000,0, 0);  // 350 flash on
    add(1,1,0, 1, L_OFF,3'b000,0,-1);  // 351
    add(1,1,0, 3, L_OFF,3'b000,0, 0);  // 354
    add(1,1,0, 1, L_Y,  3'b000,0,-1);  // 355
    add(1,0,0, 1, L_Y,  3'b000,0,-1);  // 356
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 357
    add(1,0,0,69, L_R,  3'b000,0,17);  // 426
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 427
    add(1,0,0,57, L_G,  3'b000,0,-1);  // 484
    // request raised on the yellow->red edge and held
    add(1,0,0, 1, L_Y,  3'b010,0,-1);  // 485
    add(1,0,0, 8, L_Y,  3'b000,0,-1);  // 493
    add(1,0,1, 1, L_Y,  3'b000,0,-1);  // 494
    add(1,0,1, 1, L_R,  3'b100,0,-1);  // 495 clear beats set
    add(1,0,1,69, L_R,  3'b000,0,-1);  // 564
    add(1,0,1, 1, L_G,  3'b001,0,-1);  // 565
    add(1,0,1,17, L_G,  3'b000,1,-1);  // 582 early exit
    add(1,0,1, 1, L_Y,  3'b010,1,-1);  // 583
    add(1,0,0, 9, L_Y,  3'b000,1,-1);  // 592
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 593
    add(1,0,1,60, L_R,  3'b000,0,-1);  // 653
    add(1,0,0, 9, L_R,  3'b000,0,-1);  // 662 request dropped
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 663
    add(1,0,0,57, L_G,  3'b000,0,-1);  // 720 full green
    add(1,0,0, 1, L_Y,  3'b010,0,-1);  // 721
    add(1,0,0, 9, L_Y,  3'b000,0,-1);  // 730
    add(1,0,0, 1, L_R,  3'b100,0,-1);  // 731
    add(1,0,0,69, L_R,  3'b000,0,-1);  // 800
    add(1,0,0, 1, L_G,  3'b001,0,-1);  // 801
    add(1,0,0,10, L_G,  3'b000,0,-1);  // 811

    // reset state
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset lamps", int'({o_green, o_yellow, o_red, o_ped_walk}), int'(L_Y));
    check("reset init", int'(o_init), 0);
    check("reset cnt_en", int'(o_cnt_en), 0);
    check("reset ped_pending", int'(dbg_pp), 0);
    check("reset prescaler", int'(dut.presc_q), 0);
    check("reset flash phase", int'(dut.phase_q), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      p0 = pulses;
      repeat (tbl[i].len) step(tbl[i].en, tbl[i].night, tbl[i].ped);
      check($sformatf("row%0d lamps", i), int'(s_lamps), int'(tbl[i].lamps));
      check($sformatf("row%0d init", i), int'(s_init), int'(tbl[i].init));
      check($sformatf("row%0d ped_pending", i), int'(s_pp), int'(tbl[i].pp));
      if (tbl[i].pulses >= 0)
        check($sformatf("row%0d cnt_en pulses", i), pulses - p0, tbl[i].pulses);
    end

    // asynchronous reset mid-green, then a 9-cycle yellow
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset lamps", int'({o_green, o_yellow, o_red, o_ped_walk}), int'(L_Y));
    check("midreset init", int'(o_init), 0);
    check("midreset prescaler", int'(dut.presc_q), 0);
    check("midreset cnt_en", int'(o_cnt_en), 0);
    check("midreset ped_pending", int'(dbg_pp), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    yl = 0;
    step(1, 0, 0);
    while (s_lamps == L_Y && yl < 20) begin
      yl++;
      step(1, 0, 0);
    end
    check("post-reset yellow length", yl, 9);
    check("post-reset red init", int'(s_init), 3'b100);

    // randomized stimulus against the model
    night_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) night_r = !night_r;
      en_r  = ($urandom_range(0, 11) != 0);
      ped_r = (((i / 400) % 2) == 1) && ($urandom_range(0, 5) == 0);
      step(en_r, night_r, ped_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequencing controller for one traffic-light approach; sits directly upstream of the light down-counter. It generates the counter's one-hot load strobes and count-enable ticks, consumes the counter's terminal-count flag, and drives the lamp outputs. It also handles pedestrian requests and a night-time flashing-yellow mode. The counter must be loaded with nonzero values and must reset to its yellow value, matching this block's reset state.

## Interface
- pINIT_WIDTH, 3: width of `o_init`; bit 0 = green, bit 1 = yellow, bit 2 = red.
- pTICK_DIV, 4: clk cycles per count tick. Must be ≥ 2.
- pTICK_WIDTH, 2: prescaler width, equal to $clog2(pTICK_DIV).
- pMIN_GREEN_TICKS, 4: minimum number of green ticks before a pedestrian request can end green early.
- pGT_WIDTH, 3: width of the green-tick counter. It saturates at its maximum.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  run. When low, the block freezes.
- i_night  in  1  night mode request.
- i_ped_req  in  1  pedestrian request; a level, sampled every cycle.
- i_last  in  1  counter terminal-count flag (count == 0).
- o_init  out  pINIT_WIDTH  one-hot counter load strobe. It is a register output.
- o_cnt_en  out  1  counter decrement enable.
- o_green, o_yellow, o_red  out  1  lamp drives.
- o_ped_walk  out  1  walk lamp.

## Operation
- States: YELLOW, RED, GREEN, FLASH. Reset state is YELLOW.
- Reset values:
  - state = YELLOW; `o_init` = 0; prescaler = 0; green ticks = 0; `ped_pending` = 0; flash phase = 1.
  - Outputs: `o_yellow` = 1, all other lamps 0, `o_cnt_en` = 0.
- Normal sequence: YELLOW → RED → GREEN → YELLOW. A transition fires in any cycle where `i_last` = 1, `o_init` = 0, `i_enable` = 1 and the state is not FLASH.
- Init cycle: the first cycle of each new state.
  - `o_init` carries the new state's bit for exactly 1 cycle: green = 3'b001, yellow = 3'b010, red = 3'b100.
  - `i_last` is ignored during this cycle.
  - The prescaler is held at 0.
  - `o_cnt_en` = 0.
- Prescaler:
  - Counts 0..pTICK_DIV-1 and wraps, in YELLOW, RED and GREEN outside the init cycle while `i_enable` = 1.
  - `o_cnt_en` = 1 when prescaler == pTICK_DIV-1 and the block is counting.
- Freeze (`i_enable` = 0): prescaler, state, green ticks and flash phase all hold; `o_cnt_en` = 0. A pending `o_init` still completes its single cycle.
- Pedestrian logic:
  - `ped_pending` sets on `i_ped_req` = 1 in any state except RED and FLASH.
  - `ped_pending` clears in the cycle the state becomes RED. Clear wins over a simultaneous set.
  - `o_ped_walk` = 1 exactly while state == RED.
- Early green exit: in GREEN, outside the init cycle, with `i_enable` = 1, `ped_pending` = 1 and green ticks ≥ pMIN_GREEN_TICKS, the block goes to YELLOW. If `i_last` is also asserted, the result is the same single transition to YELLOW.
- Green ticks: clears on entering GREEN and increments on each `o_cnt_en` pulse while in GREEN.
- Night mode:
  - `i_night` = 1 forces FLASH on the next edge from any state, regardless of `i_enable`. This is the highest priority after reset.
  - Entering FLASH resets the prescaler to 0 and sets flash phase = 1.
  - In FLASH: `o_yellow` = flash phase; `o_red`, `o_green`, `o_ped_walk` and `o_cnt_en` = 0. The phase toggles at each prescaler wrap. The prescaler runs only while `i_enable` = 1.
  - `i_night` = 0 while in FLASH goes to RED via a normal red init cycle; `ped_pending` is cleared.
- Priority order: rst_n > `i_night` > freeze > early exit / `i_last`.
- Lamp outputs are a decode of the state and flash-phase registers only; there are no combinational paths from inputs.

## Timing
- Load latency: the counter loads at the edge ending the init cycle. `i_last` is low from the next cycle, given a nonzero load value.
- State length with load value V and no freeze: V·pTICK_DIV + 2 cycles (1 init cycle + V ticks + 1 cycle in which `i_last` is seen).
- First YELLOW after reset release has no init cycle: V·pTICK_DIV + 1 cycles.
- Early green exit length: pMIN_GREEN_TICKS·pTICK_DIV + 2 cycles.
- Freeze cycles extend the current state 1:1.
- Reset asserted mid-state: all registers clear asynchronously. The counter reloads its yellow value through its own reset.
- Flash period: 2·pTICK_DIV cycles; the lamp is on for pTICK_DIV cycles.

## Test plan
Bench uses the downstream counter loaded with green 14, yellow 2, red 17 and default parameters.
- Reset release → YELLOW for 9 cycles, RED for 70 cycles with `o_ped_walk` = 1, GREEN for 58 cycles, YELLOW for 10 cycles. Each state entry shows a single-cycle one-hot `o_init`.
- `i_ped_req` pulse 1 cycle at green tick 1 → GREEN lasts 18 cycles, then YELLOW. `o_ped_walk` = 1 in the following RED; `ped_pending` = 0 after it.
- `i_enable` = 0 for 20 cycles mid-RED → no `o_cnt_en` pulses; RED lasts 90 cycles; lamps stable throughout.
- `i_night` = 1 mid-GREEN → FLASH next cycle; `o_yellow` toggles every 4 cycles starting high. `i_night` = 0 → RED with `o_init` = 3'b100 for 1 cycle, then a 70-cycle RED.
- `i_ped_req` asserted in the YELLOW→RED edge cycle and held through RED → `ped_pending` = 0 on RED entry. The next GREEN runs its full 58 cycles only if the request drops before GREEN; a held request causes an early exit at 18 cycles.
- rst_n pulsed low mid-GREEN → asynchronous return to YELLOW with `o_init` = 0, prescaler = 0; then a 9-cycle YELLOW.
